// File: rtl/spi_pkg.sv
// Shared constants, frame layout helper and FSM state encoding for the SPI master.
// A frame is {6'b0, cmd, data}, shifted out MSB first.
package spi_pkg;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REPLACE = 2'b11;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, END} state_e;

  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [1:0] cmd,
                                                       input logic [DATA_BITS-1:0] data);
    return {{(FRAME_BITS-DATA_BITS-2){1'b0}}, cmd, data};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus four-wire SPI bus, bundled for the master and its counterpart.
interface spi_master_if;

  logic       start;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       SCLK;
  logic       CS;
  logic       SDO;
  logic       SDI;

  modport master (
    input  start, cmd, tx_data, SDI,
    output busy, done, rx_data, SCLK, CS, SDO
  );

  modport slave (
    output start, cmd, tx_data, SDI,
    input  busy, done, rx_data, SCLK, CS, SDO
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer: o_tick pulses on the last system cycle of each SCLK phase.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one 16-bit command+data frame per accepted start, SCLK idle low,
// SDO changes on SCLK fall, SDI captured on the edge that raises SCLK.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);

  state_e                r_state;
  logic [FRAME_BITS-2:0] r_frame;
  logic [4:0]            r_bitCnt;
  logic [DATA_BITS-1:0]  r_rx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sclk;
  logic                  r_cs;
  logic                  r_sdo;

  logic                  w_accept;
  logic                  w_phaseActive;
  logic                  w_tick;
  logic [4:0]            w_nextCnt;
  logic [FRAME_BITS-1:0] w_newFrame;

  assign w_accept      = (r_state == IDLE) && bus.start;
  assign w_phaseActive = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOW);
  assign w_nextCnt     = r_bitCnt + 5'd1;
  assign w_newFrame    = buildFrame(bus.cmd, bus.tx_data);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clkGen (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (w_phaseActive),
    .o_tick   (w_tick)
  );

  // r_frame holds only the not-yet-driven bits; bit 15 goes straight to SDO on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_frame  <= '0;
      r_bitCnt <= '0;
      r_rx     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs     <= 1'b1;
      r_sdo    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_frame  <= w_newFrame[FRAME_BITS-2:0];
            r_sdo    <= w_newFrame[FRAME_BITS-1];
            r_cs     <= 1'b0;
            r_busy   <= 1'b1;
            r_bitCnt <= '0;
            r_state  <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (w_tick) begin
            if (r_state == LOW && r_bitCnt == 5'(FRAME_BITS)) begin
              r_cs    <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= END;
            end else begin
              r_sclk   <= 1'b1;
              r_bitCnt <= w_nextCnt;
              // Data-phase rises sample the slave's SDO before the slave shifts it.
              if (w_nextCnt > 5'(DATA_BITS)) begin
                r_rx <= {r_rx[DATA_BITS-2:0], bus.SDI};
              end
              r_state <= HIGH;
            end
          end
        end
        HIGH: begin
          if (w_tick) begin
            r_sclk  <= 1'b0;
            r_frame <= {r_frame[FRAME_BITS-3:0], 1'b0};
            r_sdo   <= (r_bitCnt < 5'(FRAME_BITS)) ? r_frame[FRAME_BITS-2] : 1'b0;
            r_state <= LOW;
          end
        end
        END: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx;
  assign bus.SCLK    = r_sclk;
  assign bus.CS      = r_cs;
  assign bus.SDO     = r_sdo;

endmodule
